host_bus_driver: RTL and testbench
==================================

Name: host_bus_driver

Overview:
Host-side initiator for the Xosera 8-bit register bus. It takes 16-bit register read/write requests over a valid/ready handshake and sequences each one into one or two byte cycles (even byte, then odd byte) with programmable setup, strobe and hold timing. It returns read data, or write completion, as a one-cycle response pulse. It sits in FPGA test harnesses and CPU-bridge designs that drive Xosera's bus_cs_n/bus_rd_nwr/bus_reg_num/bus_bytesel/bus_data pins.

Parameters:
SETUP_CYCLES, 1, cycles address/rd_nwr/data are stable before cs_n falls (legal range 1 or more)
STROBE_CYCLES, 3, cycles cs_n is held low per byte (legal range 1 or more)
HOLD_CYCLES, 1, cycles address/rd_nwr/data are held after cs_n rises (legal range 1 or more)

Ports:
clk  in  1  single clock
reset_n_i  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  block idle, can accept a request
req_rd_nwr_i  in  1  1 = read, 0 = write
req_reg_num_i  in  4  register number
req_bytes_i  in  2  byte mask; bit1 = even byte (data[15:8]), bit0 = odd byte (data[7:0])
req_data_i  in  16  write data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_data_o  out  16  read data; 0 for writes
bus_cs_n_o  out  1  chip select, active low
bus_rd_nwr_o  out  1  1 = read, 0 = write
bus_reg_num_o  out  4  register number
bus_bytesel_o  out  1  0 = even byte, 1 = odd byte
bus_data_o  out  8  write byte
bus_data_oe_o  out  1  drive enable for bus_data_o
bus_data_i  in  8  read byte from responder

Behaviour:
- Reset state: cs_n=1, rd_nwr=1, reg_num=0, bytesel=0, data_o=0x00, data_oe=0, rsp_valid=0, rsp_data=0x0000, FSM=IDLE. Reset applies asynchronously, including mid-transfer; an in-flight request is dropped and produces no response.
- req_ready_o = (state==IDLE). A request is accepted when valid and ready are both high (call this cycle 0). All req_* inputs are registered at accept; later changes are ignored.
- FSM states are IDLE, SETUP, STROBE, HOLD, RESP. One down-counter, sized for the maximum parameter value, times each phase.
- Per byte: SETUP for SETUP_CYCLES (cs_n=1), then STROBE for STROBE_CYCLES (cs_n=0), then HOLD for HOLD_CYCLES (cs_n=1). reg_num, rd_nwr, bytesel and data_o stay stable from the first SETUP cycle to the last HOLD cycle.
- Byte order: even byte first (bytesel=0, data[15:8]), then odd byte (bytesel=1, data[7:0]). Bytes with a 0 mask bit are skipped entirely.
- Write: data_oe=1 during SETUP, STROBE and HOLD; 0 otherwise.
- Read: data_oe stays 0. bus_data_i is sampled on the last STROBE cycle into the matching half of rsp_data. Skipped halves read as 0x00.
- After the last HOLD cycle the FSM enters RESP for one cycle (rsp_valid=1), then returns to IDLE.
- Between bytes, the HOLD of the first byte and the SETUP of the second are both serviced, so cs_n is high for HOLD_CYCLES+SETUP_CYCLES.
- Latency with defaults: a 2-byte request has cs_n low on cycles 2–4 and 7–9, rsp_valid on cycle 11, and ready on cycle 12. A 1-byte request has rsp_valid on cycle 6.
- Mask 00: no bus activity; RESP on cycle 1 with rsp_data=0.
- rsp_data holds its value until the next RESP.
- A parameter value below 1 is an elaboration-time error.

Decomposition:
- Add to the shared xv package: an enum type for the FSM states, and constants BYTESEL_EVEN=0 and BYTESEL_ODD=1.
- Reuse the existing xv::cs_ENABLED and xv::RnW_READ constants for output polarity.
- No sub-module; the phase counter and FSM are inline.

Test Plan:
1. Write, reg 3, data 0xABCD, mask 11, default parameters -> cs_n low on cycles 2–4 with bytesel=0/data 0xAB, and on cycles 7–9 with bytesel=1/data 0xCD; rd_nwr=0; oe high on cycles 1–10; rsp_valid on cycle 11 with rsp_data 0.
2. Read, reg 5, mask 11; responder drives 0x12 then 0x34 during strobes -> rsp_data=0x1234 on cycle 11; oe never asserted.
3. Write, reg 2, data 0x00EE, mask 01 -> single strobe with bytesel=1/data 0xEE on cycles 2–4; rsp_valid on cycle 6.
4. Mask 00 -> cs_n stays high throughout; rsp_valid on cycle 1 with data 0x0000; ready on cycle 2.
5. Two back-to-back requests with valid held high -> second accepted on cycle 12; cs_n high for at least 2 cycles between all strobes.
6. Assert reset_n_i low during the first STROBE -> cs_n=1 and oe=0 immediately (asynchronous); no rsp_valid; ready=1 on the first cycle after release.

Source files
------------

// File: rtl/host_bus_driver_pkg.sv
// Shared Xosera bus definitions: pin polarities, byte-lane selects and the
// host-side bus driver state type.
package xv;

    localparam logic cs_ENABLED   = 1'b0;
    localparam logic cs_DISABLED  = 1'b1;
    localparam logic RnW_READ     = 1'b1;
    localparam logic RnW_WRITE    = 1'b0;
    localparam logic BYTESEL_EVEN = 1'b0;
    localparam logic BYTESEL_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } hbd_state_t;

    function automatic logic [7:0] byte_of(input logic [15:0] word, input logic bytesel);
        if (bytesel == BYTESEL_EVEN) begin
            return word[15:8];
        end else begin
            return word[7:0];
        end
    endfunction

endpackage

// File: rtl/host_bus_driver.sv
// Host initiator for the Xosera 8-bit register bus: splits 16-bit requests into
// even/odd byte cycles with programmable setup, strobe and hold timing.
module host_bus_driver
    import xv::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 3,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rd_nwr_i,
    input  logic [3:0]  req_reg_num_i,
    input  logic [1:0]  req_bytes_i,
    input  logic [15:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i
);

    localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_SETUP  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_timing
        $error("host_bus_driver: SETUP/STROBE/HOLD cycle counts must be at least 1");
    end

    hbd_state_t       r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic             r_rd_nwr, w_rd_nwr;
    logic [3:0]       r_reg_num, w_reg_num;
    logic             r_odd_pend, w_odd_pend;
    logic [15:0]      r_wdata, w_wdata;
    logic             r_bytesel, w_bytesel;
    logic [15:0]      r_rd_acc, w_rd_acc;
    logic [15:0]      r_rsp_data, w_rsp_data;
    logic             r_rsp_valid;
    logic             r_cs_n;
    logic [7:0]       r_data_o;
    logic             r_data_oe;
    logic             w_bus_active;

    // Next-state, phase counter and request/byte-lane bookkeeping
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_rd_nwr     = r_rd_nwr;
        w_reg_num    = r_reg_num;
        w_odd_pend   = r_odd_pend;
        w_wdata      = r_wdata;
        w_bytesel    = r_bytesel;
        w_rd_acc     = r_rd_acc;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_rd_nwr   = req_rd_nwr_i;
                    w_reg_num  = req_reg_num_i;
                    w_odd_pend = req_bytes_i[0];
                    w_wdata    = req_data_i;
                    w_rd_acc   = 16'h0000;
                    if (req_bytes_i == 2'b00) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_SETUP;
                        w_next_cnt   = CNT_SETUP;
                        w_bytesel    = req_bytes_i[1] ? BYTESEL_EVEN : BYTESEL_ODD;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == CNT_ZERO) begin
                    w_next_state = ST_STROBE;
                    w_next_cnt   = CNT_STROBE;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (r_cnt == CNT_ZERO) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = CNT_HOLD;
                    // Read data is taken at the end of the strobe, when the responder is settled
                    if (r_rd_nwr == RnW_READ) begin
                        if (r_bytesel == BYTESEL_EVEN) begin
                            w_rd_acc[15:8] = bus_data_i;
                        end else begin
                            w_rd_acc[7:0] = bus_data_i;
                        end
                    end else begin
                        w_rd_acc = r_rd_acc;
                    end
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == CNT_ZERO) begin
                    if (r_bytesel == BYTESEL_EVEN && r_odd_pend) begin
                        w_next_state = ST_SETUP;
                        w_next_cnt   = CNT_SETUP;
                        w_bytesel    = BYTESEL_ODD;
                    end else begin
                        w_next_state = ST_RESP;
                    end
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_next_state == ST_RESP) begin
            w_rsp_data = (w_rd_nwr == RnW_READ) ? w_rd_acc : 16'h0000;
        end else begin
            w_rsp_data = r_rsp_data;
        end

        w_bus_active = (w_next_state == ST_SETUP) || (w_next_state == ST_STROBE)
                    || (w_next_state == ST_HOLD);
    end

    // State and registered bus/response outputs, all aligned to the next state
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_rd_nwr    <= RnW_READ;
            r_reg_num   <= 4'h0;
            r_odd_pend  <= 1'b0;
            r_wdata     <= 16'h0000;
            r_bytesel   <= BYTESEL_EVEN;
            r_rd_acc    <= 16'h0000;
            r_rsp_data  <= 16'h0000;
            r_rsp_valid <= 1'b0;
            r_cs_n      <= cs_DISABLED;
            r_data_o    <= 8'h00;
            r_data_oe   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_rd_nwr    <= w_rd_nwr;
            r_reg_num   <= w_reg_num;
            r_odd_pend  <= w_odd_pend;
            r_wdata     <= w_wdata;
            r_bytesel   <= w_bytesel;
            r_rd_acc    <= w_rd_acc;
            r_rsp_data  <= w_rsp_data;
            r_rsp_valid <= (w_next_state == ST_RESP);
            r_cs_n      <= (w_next_state == ST_STROBE) ? cs_ENABLED : cs_DISABLED;
            r_data_o    <= byte_of(w_wdata, w_bytesel);
            r_data_oe   <= w_bus_active && (w_rd_nwr != RnW_READ);
        end
    end

    assign req_ready_o   = (r_state == ST_IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign bus_cs_n_o    = r_cs_n;
    assign bus_rd_nwr_o  = r_rd_nwr;
    assign bus_reg_num_o = r_reg_num;
    assign bus_bytesel_o = r_bytesel;
    assign bus_data_o    = r_data_o;
    assign bus_data_oe_o = r_data_oe;

endmodule

// File: tb/tb_host_bus_driver.sv
// Self-checking bench for host_bus_driver: per-cycle bus timing, byte order,
// read assembly, back-to-back acceptance and asynchronous reset.
module tb_host_bus_driver;

    localparam int S   = 1;
    localparam int ST  = 3;
    localparam int H   = 1;
    localparam int PER = S + ST + H;

    logic        clk;
    logic        reset_n_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_rd_nwr_i;
    logic [3:0]  req_reg_num_i;
    logic [1:0]  req_bytes_i;
    logic [15:0] req_data_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_data_o;
    logic        bus_cs_n_o;
    logic        bus_rd_nwr_o;
    logic [3:0]  bus_reg_num_o;
    logic        bus_bytesel_o;
    logic [7:0]  bus_data_o;
    logic        bus_data_oe_o;
    logic [7:0]  bus_data_i;

    logic [7:0]  resp_even;
    logic [7:0]  resp_odd;
    logic [15:0] prev_rsp;
    int          checks = 0;
    int          errors = 0;

    host_bus_driver #(
        .SETUP_CYCLES (S),
        .STROBE_CYCLES(ST),
        .HOLD_CYCLES  (H)
    ) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_rd_nwr_i (req_rd_nwr_i),
        .req_reg_num_i(req_reg_num_i),
        .req_bytes_i  (req_bytes_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .bus_cs_n_o   (bus_cs_n_o),
        .bus_rd_nwr_o (bus_rd_nwr_o),
        .bus_reg_num_o(bus_reg_num_o),
        .bus_bytesel_o(bus_bytesel_o),
        .bus_data_o   (bus_data_o),
        .bus_data_oe_o(bus_data_oe_o),
        .bus_data_i   (bus_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: drives the selected byte only while selected, junk otherwise
    assign bus_data_i = bus_cs_n_o ? 8'hA5 : (bus_bytesel_o ? resp_odd : resp_even);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        checks++; if (bus_cs_n_o !== 1'b1)     begin errors++; $display("FAIL reset_cs_n got %b want 1", bus_cs_n_o); end
        checks++; if (bus_rd_nwr_o !== 1'b1)   begin errors++; $display("FAIL reset_rd_nwr got %b want 1", bus_rd_nwr_o); end
        checks++; if (bus_reg_num_o !== 4'h0)  begin errors++; $display("FAIL reset_reg_num got %h want 0", bus_reg_num_o); end
        checks++; if (bus_bytesel_o !== 1'b0)  begin errors++; $display("FAIL reset_bytesel got %b want 0", bus_bytesel_o); end
        checks++; if (bus_data_o !== 8'h00)    begin errors++; $display("FAIL reset_data_o got %h want 00", bus_data_o); end
        checks++; if (bus_data_oe_o !== 1'b0)  begin errors++; $display("FAIL reset_oe got %b want 0", bus_data_oe_o); end
        checks++; if (rsp_valid_o !== 1'b0)    begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
        checks++; if (rsp_data_o !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data_o); end
        checks++; if (req_ready_o !== 1'b1)    begin errors++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
        prev_rsp = 16'h0000;
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (req_ready_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_wait got %b want 1", tag, req_ready_o);
        end
    endtask

    // One request, checked every cycle from cycle 1 until ready returns
    task automatic run_txn(input logic rd, input logic [3:0] rnum, input logic [1:0] mask,
                           input logic [15:0] data, input logic [7:0] be, input logic [7:0] bo);
        int          n, k, rsp_cyc, idx, off;
        logic        sel [0:1];
        logic        exp_act, exp_cs, exp_oe;
        logic [7:0]  exp_byte;
        logic [15:0] exp_rsp;

        wait_ready("txn");
        k = 0;
        sel[0] = 1'b0;
        sel[1] = 1'b0;
        if (mask[1]) begin sel[k] = 1'b0; k = k + 1; end
        if (mask[0]) begin sel[k] = 1'b1; k = k + 1; end
        n       = k;
        rsp_cyc = n * PER + 1;
        exp_rsp = rd ? {mask[1] ? be : 8'h00, mask[0] ? bo : 8'h00} : 16'h0000;

        resp_even     = be;
        resp_odd      = bo;
        req_rd_nwr_i  = rd;
        req_reg_num_i = rnum;
        req_bytes_i   = mask;
        req_data_i    = data;
        req_valid_i   = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i   = 1'b0;
        req_rd_nwr_i  = ~rd;
        req_reg_num_i = ~rnum;
        req_bytes_i   = ~mask;
        req_data_i    = 16'($urandom);

        for (int c = 1; c <= rsp_cyc + 1; c++) begin
            @(negedge clk);
            exp_act = (c - 1) < n * PER;
            idx     = (c - 1) / PER;
            off     = (c - 1) % PER;
            if (exp_act) begin
                exp_cs = !(off >= S && off < S + ST);
                exp_oe = !rd;
            end else begin
                exp_cs = 1'b1;
                exp_oe = 1'b0;
            end
            checks++; if (bus_cs_n_o !== exp_cs) begin errors++; $display("FAIL cs_n c=%0d got %b want %b", c, bus_cs_n_o, exp_cs); end
            checks++; if (bus_data_oe_o !== exp_oe) begin errors++; $display("FAIL oe c=%0d got %b want %b", c, bus_data_oe_o, exp_oe); end
            checks++; if (rsp_valid_o !== (c == rsp_cyc)) begin errors++; $display("FAIL rsp_valid c=%0d got %b want %b", c, rsp_valid_o, (c == rsp_cyc)); end
            checks++; if (req_ready_o !== (c > rsp_cyc)) begin errors++; $display("FAIL ready c=%0d got %b want %b", c, req_ready_o, (c > rsp_cyc)); end
            if (exp_act) begin
                exp_byte = sel[idx] ? data[7:0] : data[15:8];
                checks++; if (bus_bytesel_o !== sel[idx]) begin errors++; $display("FAIL bytesel c=%0d got %b want %b", c, bus_bytesel_o, sel[idx]); end
                checks++; if (bus_reg_num_o !== rnum) begin errors++; $display("FAIL reg_num c=%0d got %h want %h", c, bus_reg_num_o, rnum); end
                checks++; if (bus_rd_nwr_o !== rd) begin errors++; $display("FAIL rd_nwr c=%0d got %b want %b", c, bus_rd_nwr_o, rd); end
                if (!rd) begin
                    checks++; if (bus_data_o !== exp_byte) begin errors++; $display("FAIL data_o c=%0d got %h want %h", c, bus_data_o, exp_byte); end
                end
            end
            if (c < rsp_cyc) begin
                checks++; if (rsp_data_o !== prev_rsp) begin errors++; $display("FAIL rsp_hold c=%0d got %h want %h", c, rsp_data_o, prev_rsp); end
            end else begin
                checks++; if (rsp_data_o !== exp_rsp) begin errors++; $display("FAIL rsp_data c=%0d got %h want %h", c, rsp_data_o, exp_rsp); end
            end
        end
        prev_rsp = exp_rsp;
    endtask

    task automatic test_write_full();
        run_txn(1'b0, 4'd3, 2'b11, 16'hABCD, 8'h00, 8'h00);
    endtask

    task automatic test_read_full();
        run_txn(1'b1, 4'd5, 2'b11, 16'h5A5A, 8'h12, 8'h34);
    endtask

    task automatic test_single_odd();
        run_txn(1'b0, 4'd2, 2'b01, 16'h00EE, 8'h00, 8'h00);
        run_txn(1'b1, 4'd6, 2'b10, 16'h0000, 8'h9C, 8'h77);
    endtask

    task automatic test_mask_none();
        run_txn(1'b0, 4'd4, 2'b00, 16'h1357, 8'h00, 8'h00);
        run_txn(1'b1, 4'd8, 2'b00, 16'h0000, 8'hFF, 8'hFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn(1'($urandom), 4'($urandom), 2'($urandom), 16'($urandom),
                    8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        localparam int B = 2 * PER + 2;
        logic [15:0] d1, d2, d;
        int          rel, idx, off, last_low, gap;
        logic        exp_cs, exp_ready, exp_rsp, act;
        logic [7:0]  exp_byte;

        d1 = 16'($urandom);
        d2 = 16'($urandom);
        wait_ready("b2b");
        req_rd_nwr_i  = 1'b0;
        req_reg_num_i = 4'd1;
        req_bytes_i   = 2'b11;
        req_data_i    = d1;
        req_valid_i   = 1'b1;
        last_low      = -100;
        for (int c = 1; c <= 2 * B; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                req_reg_num_i = 4'd9;
                req_data_i    = d2;
            end
            if (c == B + 1) req_valid_i = 1'b0;
            @(negedge clk);
            rel       = (c < B) ? c : c - B;
            d         = (c < B) ? d1 : d2;
            act       = (rel >= 1) && (rel <= 2 * PER);
            idx       = (rel - 1) / PER;
            off       = (rel - 1) % PER;
            exp_cs    = act ? !(off >= S && off < S + ST) : 1'b1;
            exp_ready = (rel == 0) || (rel > 2 * PER + 1);
            exp_rsp   = (rel == 2 * PER + 1);
            checks++; if (bus_cs_n_o !== exp_cs) begin errors++; $display("FAIL b2b_cs_n c=%0d got %b want %b", c, bus_cs_n_o, exp_cs); end
            checks++; if (req_ready_o !== exp_ready) begin errors++; $display("FAIL b2b_ready c=%0d got %b want %b", c, req_ready_o, exp_ready); end
            checks++; if (rsp_valid_o !== exp_rsp) begin errors++; $display("FAIL b2b_rsp_valid c=%0d got %b want %b", c, rsp_valid_o, exp_rsp); end
            if (act && !exp_cs) begin
                exp_byte = (idx == 0) ? d[15:8] : d[7:0];
                checks++; if (bus_data_o !== exp_byte) begin errors++; $display("FAIL b2b_data_o c=%0d got %h want %h", c, bus_data_o, exp_byte); end
            end
            if (bus_cs_n_o === 1'b0) begin
                gap = c - last_low - 1;
                if (gap > 0) begin
                    checks++; if (gap < H + S) begin errors++; $display("FAIL b2b_gap c=%0d got %0d want >=%0d", c, gap, H + S); end
                end
                last_low = c;
            end
        end
        prev_rsp = 16'h0000;
    endtask

    task automatic test_async_reset();
        wait_ready("arst");
        req_rd_nwr_i  = 1'b0;
        req_reg_num_i = 4'd7;
        req_bytes_i   = 2'b11;
        req_data_i    = 16'hC3C3;
        req_valid_i   = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL arst_strobe_cs_n got %b want 0", bus_cs_n_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL arst_cs_n got %b want 1", bus_cs_n_o); end
        checks++; if (bus_data_oe_o !== 1'b0) begin errors++; $display("FAIL arst_oe got %b want 0", bus_data_oe_o); end
        @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready got %b want 1", req_ready_o); end
        for (int c = 0; c < 14; c++) begin
            checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL arst_no_rsp c=%0d got %b want 0", c, rsp_valid_o); end
            @(negedge clk);
        end
        checks++; if (rsp_data_o !== 16'h0000) begin errors++; $display("FAIL arst_rsp_data got %h want 0000", rsp_data_o); end
        prev_rsp = 16'h0000;
    endtask

    initial begin
        reset_n_i     = 1'b0;
        req_valid_i   = 1'b0;
        req_rd_nwr_i  = 1'b0;
        req_reg_num_i = 4'h0;
        req_bytes_i   = 2'b00;
        req_data_i    = 16'h0000;
        resp_even     = 8'h00;
        resp_odd      = 8'h00;
        prev_rsp      = 16'h0000;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n_i = 1'b1;
        @(negedge clk);
        test_write_full();
        test_read_full();
        test_single_odd();
        test_mask_none();
        test_random();
        test_back_to_back();
        test_async_reset();
        test_read_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
